// File: rtl/imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into imem words and holds the core in reset until the image is in.
// Optional checksum trailer is compiled in with IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int         ADDR_W         = 8,
  parameter logic [7:0] MAGIC          = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready.
  // rx_ready is low only while in reset; the loader never backpressures.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam int              TW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]     CAP  = 33'd1 << ADDR_W;

  state_t              state;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          bcnt;
  logic [23:0]         wbuf;
  logic [TW-1:0]       tcnt;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_acc;
`endif

  logic        acc;
  logic        is_magic;
  logic        timed;
  logic        last_word;
  logic [15:0] n_len;

  assign acc       = rx_valid && rx_ready;
  assign is_magic  = (rx_data == MAGIC);
  assign timed     = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CSUM);
  assign last_word = (32'(word_idx) == (32'(len) - 32'd1));
  assign n_len     = {rx_data, len_lo};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      bcnt       <= '0;
      wbuf       <= '0;
      tcnt       <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_acc   <= '0;
`endif
    end else begin
      rx_ready <= 1'b1;
      imem_we  <= 1'b0;

      if (timed && !acc) tcnt <= tcnt + 1'b1;
      else               tcnt <= '0;

      case (state)
        S_IDLE: begin
          if (acc && is_magic) begin
            state    <= S_LEN0;
            word_idx <= '0;
            bcnt     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_acc <= '0;
`endif
          end
        end
        S_LEN0: begin
          if (acc) begin
            len_lo <= rx_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (acc) begin
            len <= n_len;
            if (33'(n_len) > CAP) begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else if (n_len == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (acc) begin
            wbuf <= {rx_data, wbuf[23:8]};
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_acc <= csum_acc ^ rx_data;
`endif
            if (bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {rx_data, wbuf};
              word_idx   <= word_idx + 1'b1;
              if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                state <= S_CSUM;
`else
                // done follows one cycle after the final write strobe
                state <= S_DONE;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (acc) begin
            if (rx_data == csum_acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= 2'b10;
            end
          end
        end
`endif
        S_DONE: begin
          if (acc && is_magic) begin
            state    <= S_LEN0;
            done     <= 1'b0;
            core_rst <= 1'b1;
            word_idx <= '0;
            bcnt     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_acc <= '0;
`endif
          end else begin
            done     <= 1'b1;
            core_rst <= 1'b0;
          end
        end
        S_ERROR: begin
          if (acc && is_magic) begin
            state    <= S_LEN0;
            err      <= 1'b0;
            err_code <= 2'b00;
            word_idx <= '0;
            bcnt     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_acc <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase

      // Inter-byte silence inside a frame aborts the load
      if (timed && !acc && (tcnt == TMAX)) begin
        state    <= S_ERROR;
        err      <= 1'b1;
        err_code <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed vectors from a table plus hand-written
// timeout, capacity and mid-frame reset sequences.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int TMO    = 16;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [2:0]        state_dbg;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .MAGIC(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .done(done),
    .err(err),
    .err_code(err_code),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected {addr, data} for every write strobe, in order
  logic [ADDR_W+31:0] exp_q[$];

  always @(negedge clk) begin
    if (imem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  typedef struct packed {
    logic [7:0]        nbytes;
    logic [127:0]      b;       // first byte in the MSBs
    logic              has_csum;
    logic [7:0]        csum;
    logic [7:0]        gap;
    logic [7:0]        nwr;
    logic [3:0][31:0]  w;
    logic              e_done;
    logic              e_err;
    logic [1:0]        e_code;
  } vec_t;

  function automatic vec_t mkv(input int nb, input logic [127:0] b, input logic hc,
                               input logic [7:0] cs, input int gap, input int nwr,
                               input logic [127:0] w, input logic d, input logic e,
                               input logic [1:0] c);
    vec_t v;
    v.nbytes = 8'(nb);  v.b = b;       v.has_csum = hc; v.csum = cs;
    v.gap = 8'(gap);    v.nwr = 8'(nwr); v.w = w;
    v.e_done = d;       v.e_err = e;   v.e_code = c;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int nb;
    nb = int'(v.nbytes);
    for (int k = 0; k < int'(v.nwr); k++) exp_q.push_back({8'(k), v.w[k]});
    for (int i = 0; i < nb; i++) begin
      send_byte(v.b[127-8*i -: 8]);
      if (v.gap != 0 && (i != nb-1 || (CSUM_EN && v.has_csum))) idle(int'(v.gap));
    end
    if (CSUM_EN && v.has_csum) send_byte(v.csum);
    // done/err visible one cycle after the deciding edge
    chk({nm, "_done_now"}, 64'(done), 64'(v.e_done && (CSUM_EN || v.nwr == 0)));
    chk({nm, "_err_now"},  64'(err),  64'(v.e_err));
    idle(3);
    chk({nm, "_done"},     64'(done),     64'(v.e_done));
    chk({nm, "_core_rst"}, 64'(core_rst), 64'(!v.e_done));
    chk({nm, "_err"},      64'(err),      64'(v.e_err));
    chk({nm, "_err_code"}, 64'(err_code), 64'(v.e_code));
    chk({nm, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs[$];
  vec_t frame1;

  initial begin
    // frame1: A5 02 00 13 00 00 00 B3 81 20 00 [01]
    frame1 = mkv(11, 128'hA5020013_000000B3_81200000_00000000, 1'b1, 8'h01, 0, 2,
                 {32'h0, 32'h0, 32'h002081B3, 32'h00000013}, 1'b1, 1'b0, 2'b00);

    vecs.push_back(mkv(14, 128'h00FF13A5_02001300_0000B381_20000000, 1'b1, 8'h01, 0, 2,
                       {32'h0, 32'h0, 32'h002081B3, 32'h00000013}, 1'b1, 1'b0, 2'b00));
    vecs.push_back(mkv(7, 128'hA50100A5_00000000_00000000_00000000, 1'b1, 8'hA5, 0, 1,
                       {32'h0, 32'h0, 32'h0, 32'h000000A5}, 1'b1, 1'b0, 2'b00));
    vecs.push_back(mkv(3, 128'hA5010100_00000000_00000000_00000000, 1'b0, 8'h00, 0, 0,
                       128'h0, 1'b0, 1'b1, 2'b01));
    vecs.push_back(mkv(3, 128'hA5FFFF00_00000000_00000000_00000000, 1'b0, 8'h00, 0, 0,
                       128'h0, 1'b0, 1'b1, 2'b01));
    vecs.push_back(mkv(15, 128'hA5030011_22334455_667788DE_ADBEEF00, 1'b1, 8'hAA, 3, 3,
                       {32'h0, 32'hEFBEADDE, 32'h88776655, 32'h44332211}, 1'b1, 1'b0, 2'b00));
    vecs.push_back(mkv(3, 128'hA5000000_00000000_00000000_00000000, 1'b1, 8'h00, 0, 0,
                       128'h0, 1'b1, 1'b0, 2'b00));
`ifdef IMEM_LOADER_CSUM_EN
    vecs.push_back(mkv(11, 128'hA5020013_000000B3_81200000_00000000, 1'b1, 8'h02, 0, 2,
                       {32'h0, 32'h0, 32'h002081B3, 32'h00000013}, 1'b0, 1'b1, 2'b10));
`endif
    vecs.push_back(frame1);

    // reset state
    rst = 1'b1;
    idle(3);
    chk("rst_rx_ready",   64'(rx_ready),   64'd0);
    chk("rst_imem_we",    64'(imem_we),    64'd0);
    chk("rst_imem_addr",  64'(imem_addr),  64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_core_rst",   64'(core_rst),   64'd1);
    chk("rst_done",       64'(done),       64'd0);
    chk("rst_err",        64'(err),        64'd0);
    chk("rst_err_code",   64'(err_code),   64'd0);
    rst = 1'b0;
    idle(1);
    chk("ready_after_rst", 64'(rx_ready), 64'd1);
    idle(40);
    chk("idle_no_timeout", 64'(err), 64'd0);
    chk("idle_core_rst",   64'(core_rst), 64'd1);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // no timeout while DONE, then a stalled frame times out on the exact edge
    idle(40);
    chk("done_no_timeout", 64'(done), 64'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    idle(TMO - 1);
    chk("timeout_early_err", 64'(err), 64'd0);
    idle(1);
    chk("timeout_err",      64'(err),      64'd1);
    chk("timeout_code",     64'(err_code), 64'd3);
    chk("timeout_core_rst", 64'(core_rst), 64'd1);
    run_vec(vecs[1], "recover");

    // full-capacity image, N = 2**ADDR_W
    begin
      logic [7:0]  cs;
      logic [31:0] wd;
      cs = 8'h00;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      for (int k = 0; k < 256; k++) begin
        wd = {8'(k), ~8'(k), 8'(k) ^ 8'h5A, 8'hC3};
        exp_q.push_back({8'(k), wd});
        for (int j = 0; j < 4; j++) begin
          send_byte(wd[8*j +: 8]);
          cs = cs ^ wd[8*j +: 8];
        end
      end
      if (CSUM_EN) send_byte(cs);
      idle(3);
      chk("cap_done", 64'(done), 64'd1);
      chk("cap_writes_seen", 64'(exp_q.size()), 64'd0);
    end

    // MAGIC restarts a finished load, then reset lands mid-frame
    send_byte(8'hA5);
    chk("restart_done",     64'(done),     64'd0);
    chk("restart_core_rst", 64'(core_rst), 64'd1);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    rst = 1'b1;
    idle(1);
    chk("midrst_rx_ready",   64'(rx_ready),   64'd0);
    chk("midrst_imem_we",    64'(imem_we),    64'd0);
    chk("midrst_imem_addr",  64'(imem_addr),  64'd0);
    chk("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("midrst_core_rst",   64'(core_rst),   64'd1);
    chk("midrst_done",       64'(done),       64'd0);
    chk("midrst_err",        64'(err),        64'd0);
    chk("midrst_err_code",   64'(err_code),   64'd0);
    rst = 1'b0;
    idle(1);
    run_vec(frame1, "after_rst");

    idle(2);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader sitting directly upstream of the single-cycle `riscv` core's instruction memory. It receives a framed program image from a byte source (UART RX), assembles little-endian 32-bit words, and writes them into imem through a word-addressed write port. It holds the core in reset until a complete, verified image has been written, replacing simulation-only image loading with a synthesizable boot path.

## Interface
- `ADDR_W`, default 8: imem word-address width; capacity is 2**ADDR_W words.
- `MAGIC`, default 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, default 100000: maximum idle cycles allowed between bytes inside a frame.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  imem write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  imem word address.
- `imem_wdata`  out  32  imem write data.
- `core_rst`  out  1  reset to the core; high until load completes.
- `done`  out  1  image loaded and verified.
- `err`  out  1  frame error latched.
- `err_code`  out  2  error cause: 01 length overflow, 10 checksum mismatch, 11 timeout.

## Operation
- Frame format: MAGIC, LEN_LO, LEN_HI (16-bit word count N), N×4 data bytes (LSB first per word), CSUM (XOR of all data bytes only).
- A byte is accepted on a rising edge where `rx_valid && rx_ready`. `rx_ready` is 0 while `rst` is high and 1 at all other times; the loader never backpressures.
- States:
  - IDLE: non-MAGIC bytes are discarded. MAGIC transitions to LEN0.
  - LEN0: latch low byte, then go to LEN1.
  - LEN1: latch high byte. If N > 2**ADDR_W, go to ERROR with code 01. If N == 0, go to CSUM. Otherwise go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into the word. On the 4th byte, write the word at the current word index. After word N-1, go to CSUM.
  - CSUM: compare the received byte with the running XOR. A match goes to DONE; a mismatch goes to ERROR with code 10.
  - DONE: `done`=1 and `core_rst`=0. Non-MAGIC bytes are ignored. MAGIC restarts the load: go to LEN0, clear `done`, and assert `core_rst`.
  - ERROR: `err`=1 and `core_rst`=1. Non-MAGIC bytes are ignored. MAGIC goes to LEN0 and clears `err` and `err_code`.
- The word index and XOR accumulator clear on entry to LEN0.
- A MAGIC-valued byte inside LEN0 through CSUM is treated as ordinary payload.
- Timeout applies in LEN0, LEN1, DATA and CSUM only:
  - The counter clears on every accepted byte and increments on every other edge.
  - On the edge where the counter equals TIMEOUT_CYCLES-1 and no byte is accepted, go to ERROR with code 11.
- Data writes already issued are not rolled back on error.
- Reset values: state IDLE, `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=1, `done`=0, `err`=0, `err_code`=00.
- `rst` overrides all activity, including mid-frame. The next frame loads from address 0.

## Timing
- All outputs are registered.
- `imem_we` is high for exactly the one cycle after the edge that accepts a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that same cycle.
- Back-to-back bytes, one per cycle, are supported. Word k's write never overlaps word k+1's assembly.
- `done` rises and `core_rst` falls in the cycle after the edge accepting a correct CSUM.
- `err` and `err_code` update in the cycle after the failing edge.
- For a timeout, `err` is visible TIMEOUT_CYCLES edges after the last accepted byte.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined: the CSUM byte is required and verified as described above.
- `IMEM_LOADER_CSUM_EN` undefined:
  - No CSUM byte is expected and the XOR accumulator is removed.
  - After the write of the last word, or after LEN1 when N == 0, the loader goes directly to DONE.
  - `done` rises in the cycle after the last `imem_we` pulse, or in the cycle after LEN1 is accepted when N == 0.
  - Error code 10 cannot occur.

## Test plan
- Valid frame, CSUM_EN, back-to-back: A5 02 00 13 00 00 00 B3 81 20 00 01 -> writes addr0=00000013 and addr1=002081B3. `done`=1, `core_rst`=0, `err`=0.
- Same frame with CSUM 02 -> both words are written. Then `err`=1, `err_code`=10, `core_rst` stays 1, `done`=0.
- A5 01 01 with ADDR_W=8 (N=257) -> no `imem_we` pulses, `err_code`=01.
- TIMEOUT_CYCLES=16: A5 01 00 13 00 then silence -> `err_code`=11 exactly 16 edges after the 00 byte, no write. A following valid frame recovers: `err` clears and `done`=1.
- Leading garbage 00 FF 13, then the first valid frame -> garbage ignored, identical writes and `done`=1. A MAGIC-valued data byte (word 000000A5) is written correctly.
- `rst` pulsed for one cycle after 2 data bytes -> all outputs take reset values on the next edge. A subsequent full frame writes from addr 0. With CSUM_EN undefined, the 11-byte frame without CSUM gives `done`=1.
